// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared types, BCD limits and field-step helpers for the
//               multi-channel alarm setter.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package alarm_pkg;

    localparam logic [3:0] MIN_TENS_MAX       = 4'd5;
    localparam logic [3:0] HOUR_TENS_MAX      = 4'd2;
    localparam logic [3:0] HOUR_ONES_MAX_AT_2 = 4'd3;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hour_tens;
        bcd_t hour_ones;
        bcd_t min_tens;
        bcd_t min_ones;
    } alarm_time_t;

    // Width of the channel select; a single channel still needs one bit
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Step the minute field by one, wrapping 59<->00 with no hour carry
    function automatic alarm_time_t step_minute(input alarm_time_t t, input logic down);
        alarm_time_t r;
        r = t;
        if (!down) begin
            if (t.min_ones == 4'd9) begin
                r.min_ones = 4'd0;
                r.min_tens = (t.min_tens >= MIN_TENS_MAX) ? 4'd0 : t.min_tens + 4'd1;
            end else begin
                r.min_ones = t.min_ones + 4'd1;
            end
        end else begin
            if (t.min_ones == 4'd0) begin
                r.min_ones = 4'd9;
                r.min_tens = (t.min_tens == 4'd0) ? MIN_TENS_MAX : t.min_tens - 4'd1;
            end else begin
                r.min_ones = t.min_ones - 4'd1;
            end
        end
        return r;
    endfunction

    // Step the hour field by one, wrapping 23<->00
    function automatic alarm_time_t step_hour(input alarm_time_t t, input logic down);
        alarm_time_t r;
        r = t;
        if (!down) begin
            if (t.hour_tens == HOUR_TENS_MAX && t.hour_ones >= HOUR_ONES_MAX_AT_2) begin
                r.hour_tens = 4'd0;
                r.hour_ones = 4'd0;
            end else if (t.hour_ones == 4'd9) begin
                r.hour_ones = 4'd0;
                r.hour_tens = t.hour_tens + 4'd1;
            end else begin
                r.hour_ones = t.hour_ones + 4'd1;
            end
        end else begin
            if (t.hour_tens == 4'd0 && t.hour_ones == 4'd0) begin
                r.hour_tens = HOUR_TENS_MAX;
                r.hour_ones = HOUR_ONES_MAX_AT_2;
            end else if (t.hour_ones == 4'd0) begin
                r.hour_ones = 4'd9;
                r.hour_tens = t.hour_tens - 4'd1;
            end else begin
                r.hour_ones = t.hour_ones - 4'd1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat
// Description : Rising-edge detect plus hold-to-auto-repeat for one key.
//               o_step fires on the edge that first samples the key high,
//               then once after REPEAT_DELAY held cycles (the first-step
//               cycle counts as cycle 1), then every REPEAT_RATE cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat #(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    input  logic i_enable,
    output logic o_step
);

    logic             r_key_q;
    logic             r_active;
    logic             r_repeating;
    logic [CNT_W-1:0] r_cnt;

    logic             w_rise;
    logic             w_repeat_hit;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_limit;

    assign w_rise       = i_key & ~r_key_q;
    assign w_cnt_next   = r_cnt + CNT_W'(1);
    assign w_limit      = r_repeating ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);
    assign w_repeat_hit = r_active & i_key & r_key_q & (w_cnt_next == w_limit);
    assign o_step       = i_enable & (w_rise | w_repeat_hit);

    // Key history and hold counter; release or leaving setting mode stops the hold
    always_ff @(posedge clk) begin
        if (rst) begin
            // Capture the live level so a key held through reset is not seen as a new press
            r_key_q     <= i_key;
            r_active    <= 1'b0;
            r_repeating <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_key_q <= i_key;
            if (!i_key || !i_enable) begin
                r_active    <= 1'b0;
                r_repeating <= 1'b0;
                r_cnt       <= '0;
            end else if (w_rise) begin
                r_active    <= 1'b1;
                r_repeating <= 1'b0;
                r_cnt       <= CNT_W'(1);
            end else if (r_active) begin
                if (w_repeat_hit) begin
                    r_repeating <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt       <= w_cnt_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_set_ctrl
// Description : Multi-channel BCD alarm-time setter and comparator. Steps the
//               selected channel with auto-repeat, toggles per-channel enable
//               and pulses a per-channel match on the seconds rollover.
// Revision    : 1.0 - multi-channel successor to the minute-only setter
// ============================================================================
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter  int NUM_ALARMS   = 2,
    parameter  int REPEAT_DELAY = 500,
    parameter  int REPEAT_RATE  = 100,
    parameter  int CNT_W        = 16,
    localparam int SEL_W        = sel_w(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  CLR_n,
    input  logic                  isSettingAlarm,
    input  logic [SEL_W-1:0]      sel_alarm,
    input  logic                  minute_setting,
    input  logic                  hour_setting,
    input  logic                  dir_down,
    input  logic                  en_toggle,
    input  logic [3:0]            cur_hour_tens,
    input  logic [3:0]            cur_hour_ones,
    input  logic [3:0]            cur_min_tens,
    input  logic [3:0]            cur_min_ones,
    input  logic                  sec_zero,
    output logic [3:0]            alarm_hour_tens,
    output logic [3:0]            alarm_hour_ones,
    output logic [3:0]            alarm_minute_tens,
    output logic [3:0]            alarm_minute_ones,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] alarm_match
);

    alarm_time_t           r_alarm [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_en;
    logic [NUM_ALARMS-1:0] r_match;
    logic                  r_en_key_q;
    alarm_time_t           r_disp;

    logic                  w_min_step;
    logic                  w_hour_step;
    logic                  w_en_rise;
    logic [NUM_ALARMS-1:0] w_sel_hit;
    alarm_time_t           w_sel_time;
    alarm_time_t           w_next_time;
    alarm_time_t           w_cur_time;

    assign w_cur_time = '{hour_tens: cur_hour_tens, hour_ones: cur_hour_ones,
                          min_tens:  cur_min_tens,  min_ones:  cur_min_ones};
    assign w_en_rise  = en_toggle & ~r_en_key_q & isSettingAlarm;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .CNT_W        (CNT_W)
    ) u_min_key (
        .clk      (clk),
        .rst      (CLR_n),
        .i_key    (minute_setting),
        .i_enable (isSettingAlarm),
        .o_step   (w_min_step)
    );

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .CNT_W        (CNT_W)
    ) u_hour_key (
        .clk      (clk),
        .rst      (CLR_n),
        .i_key    (hour_setting),
        .i_enable (isSettingAlarm),
        .o_step   (w_hour_step)
    );

    // Decode the selected channel; an out-of-range select hits nothing and reads as 00:00
    always_comb begin
        w_sel_hit  = '0;
        w_sel_time = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_alarm == SEL_W'(i)) begin
                w_sel_hit[i] = 1'b1;
                w_sel_time   = r_alarm[i];
            end
        end
    end

    // Minute and hour fields are independent, so both steps may apply in one cycle
    always_comb begin
        w_next_time = w_sel_time;
        if (w_min_step) begin
            w_next_time = step_minute(w_next_time, dir_down);
        end
        if (w_hour_step) begin
            w_next_time = step_hour(w_next_time, dir_down);
        end
    end

    // Channel time storage, written only for the selected channel
    always_ff @(posedge clk) begin
        if (CLR_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_alarm[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (w_sel_hit[i] && (w_min_step || w_hour_step)) begin
                    r_alarm[i] <= w_next_time;
                end
            end
        end
    end

    // Enable key edge detect and per-channel enable toggle
    always_ff @(posedge clk) begin
        if (CLR_n) begin
            // Live level captured so a key held through reset does not toggle
            r_en_key_q <= en_toggle;
            r_en       <= '0;
        end else begin
            r_en_key_q <= en_toggle;
            if (w_en_rise) begin
                r_en <= r_en ^ w_sel_hit;
            end
        end
    end

    // Registered display mux of the selected channel
    always_ff @(posedge clk) begin
        if (CLR_n) begin
            r_disp <= '0;
        end else begin
            r_disp <= w_sel_time;
        end
    end

    // One-cycle match pulse per channel on the seconds rollover, suppressed while setting
    always_ff @(posedge clk) begin
        if (CLR_n) begin
            r_match <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_match[i] <= sec_zero & r_en[i] & ~isSettingAlarm & (w_cur_time == r_alarm[i]);
            end
        end
    end

    assign alarm_hour_tens   = r_disp.hour_tens;
    assign alarm_hour_ones   = r_disp.hour_ones;
    assign alarm_minute_tens = r_disp.min_tens;
    assign alarm_minute_ones = r_disp.min_ones;
    assign alarm_en          = r_en;
    assign alarm_match       = r_match;

endmodule
`default_nettype wire

// File: tb/tb_alarm_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_set_ctrl
// Description : Self-checking bench for alarm_set_ctrl (2- and 3-channel builds)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_set_ctrl;

    localparam int RD = 10;
    localparam int RR = 4;

    logic       clk = 1'b0;
    logic       CLR_n = 1'b1;
    logic       isSettingAlarm = 1'b0;
    logic       sel2 = 1'b0;
    logic [1:0] sel3 = 2'd0;
    logic       minute_setting = 1'b0;
    logic       hour_setting = 1'b0;
    logic       dir_down = 1'b0;
    logic       en_toggle = 1'b0;
    logic [3:0] cht = 4'd0, cho = 4'd0, cmt = 4'd0, cmo = 4'd0;
    logic       sec_zero = 1'b0;

    logic [3:0] d2_ht, d2_ho, d2_mt, d2_mo;
    logic [1:0] d2_en, d2_match;
    logic [3:0] d3_ht, d3_ho, d3_mt, d3_mo;
    logic [2:0] d3_en, d3_match;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alarm_set_ctrl #(.NUM_ALARMS(2), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(16)) dut2 (
        .clk(clk), .CLR_n(CLR_n), .isSettingAlarm(isSettingAlarm), .sel_alarm(sel2),
        .minute_setting(minute_setting), .hour_setting(hour_setting), .dir_down(dir_down),
        .en_toggle(en_toggle), .cur_hour_tens(cht), .cur_hour_ones(cho),
        .cur_min_tens(cmt), .cur_min_ones(cmo), .sec_zero(sec_zero),
        .alarm_hour_tens(d2_ht), .alarm_hour_ones(d2_ho),
        .alarm_minute_tens(d2_mt), .alarm_minute_ones(d2_mo),
        .alarm_en(d2_en), .alarm_match(d2_match));

    alarm_set_ctrl #(.NUM_ALARMS(3), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(16)) dut3 (
        .clk(clk), .CLR_n(CLR_n), .isSettingAlarm(isSettingAlarm), .sel_alarm(sel3),
        .minute_setting(minute_setting), .hour_setting(hour_setting), .dir_down(dir_down),
        .en_toggle(en_toggle), .cur_hour_tens(cht), .cur_hour_ones(cho),
        .cur_min_tens(cmt), .cur_min_ones(cmo), .sec_zero(sec_zero),
        .alarm_hour_tens(d3_ht), .alarm_hour_ones(d3_ho),
        .alarm_minute_tens(d3_mt), .alarm_minute_ones(d3_mo),
        .alarm_en(d3_en), .alarm_match(d3_match));

    wire [15:0] disp2 = {d2_ht, d2_ho, d2_mt, d2_mo};
    wire [15:0] disp3 = {d3_ht, d3_ho, d3_mt, d3_mo};

    typedef struct {
        logic        sel;
        logic        setting;
        logic        dir;
        logic        kmin;
        logic        khr;
        logic        ken;
        logic [15:0] exp_disp;
        logic [1:0]  exp_en;
    } vec_t;

    vec_t vecs [13];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle press of the chosen keys followed by a one-cycle release
    task automatic press(input logic km, input logic kh, input logic ke);
        minute_setting = km;
        hour_setting   = kh;
        en_toggle      = ke;
        cyc(1);
        minute_setting = 1'b0;
        hour_setting   = 1'b0;
        en_toggle      = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        CLR_n = 1'b1;
        cyc(1);
        CLR_n = 1'b0;
    endtask

    initial begin
        // sel setting dir kmin khr ken  expected display  expected enable
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0059, 2'b00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2300, 2'b00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0101, 2'b00};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2'b10};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2'b11};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2'b10};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0059, 2'b10};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 2'b10};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b10};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 2'b10};

        // ---------------- reset state ----------------
        CLR_n = 1'b1;
        cyc(3);
        CLR_n = 1'b0;
        check("reset_disp2", 32'(disp2), 32'h0000);
        check("reset_en2", 32'(d2_en), 32'h0);
        check("reset_match2", 32'(d2_match), 32'h0);
        check("reset_en3", 32'(d3_en), 32'h0);

        // ---------------- table-driven single presses ----------------
        for (int i = 0; i < 13; i++) begin
            sel2           = vecs[i].sel;
            isSettingAlarm = vecs[i].setting;
            dir_down       = vecs[i].dir;
            press(vecs[i].kmin, vecs[i].khr, vecs[i].ken);
            check($sformatf("vec%0d_disp", i), 32'(disp2), 32'(vecs[i].exp_disp));
            check($sformatf("vec%0d_en", i), 32'(d2_en), 32'(vecs[i].exp_en));
        end

        // ---------------- 61 minute presses wrap without hour carry ----------------
        isSettingAlarm = 1'b1;
        do_reset();
        sel2 = 1'b0; dir_down = 1'b0;
        for (int i = 0; i < 61; i++) press(1'b1, 1'b0, 1'b0);
        check("min61_wrap", 32'(disp2), 32'h0001);

        // ---------------- hour carries 09->10, 19->20, 23->00 ----------------
        sel2 = 1'b1;
        for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 1'b0);
        check("hour_09", 32'(disp2), 32'h0900);
        press(1'b0, 1'b1, 1'b0);
        check("hour_09_to_10", 32'(disp2), 32'h1000);
        for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("hour_19_to_20", 32'(disp2), 32'h2000);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("hour_23_to_00", 32'(disp2), 32'h0000);
        sel2 = 1'b0;
        cyc(2);
        check("ch0_untouched", 32'(disp2), 32'h0001);

        // ---------------- auto-repeat: RD + 3*RR held cycles -> 5 steps ----------------
        do_reset();
        sel2 = 1'b0; sel3 = 2'd0; dir_down = 1'b0;
        minute_setting = 1'b1;
        cyc(RD + 3 * RR);
        minute_setting = 1'b0;
        cyc(2);
        check("repeat_5_steps", 32'(disp2), 32'h0005);
        check("repeat_5_steps_d3", 32'(disp3), 32'h0005);
        cyc(3 * RD);
        check("repeat_stops_on_release", 32'(disp2), 32'h0005);

        // ---------------- direction change mid-hold ----------------
        do_reset();
        minute_setting = 1'b1;
        cyc(RD - 1);
        check("hold_before_repeat", 32'(disp2), 32'h0001);
        dir_down = 1'b1;
        cyc(1);
        minute_setting = 1'b0;
        cyc(2);
        check("dir_change_mid_hold", 32'(disp2), 32'h0000);
        dir_down = 1'b0;

        // ---------------- reset mid-hold ----------------
        do_reset();
        sel2 = 1'b0;
        for (int i = 0; i < 12; i++) press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 34; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("preset_1234", 32'(disp2), 32'h1234);
        check("preset_en", 32'(d2_en), 32'h1);
        minute_setting = 1'b1;
        cyc(RD + 5);
        CLR_n = 1'b1;
        cyc(1);
        CLR_n = 1'b0;
        check("midhold_reset_disp", 32'(disp2), 32'h0000);
        check("midhold_reset_en", 32'(d2_en), 32'h0);
        cyc(3 * RD);
        check("no_step_after_reset_hold", 32'(disp2), 32'h0000);
        minute_setting = 1'b0;
        cyc(1);
        press(1'b1, 1'b0, 1'b0);
        check("repress_after_reset", 32'(disp2), 32'h0001);

        // ---------------- match on ch1 at 07:30 ----------------
        do_reset();
        sel2 = 1'b1;
        for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("ch1_0730", 32'(disp2), 32'h0730);
        isSettingAlarm = 1'b0;
        cht = 4'd0; cho = 4'd7; cmt = 4'd3; cmo = 4'd0;
        cyc(1);
        check("no_match_without_sec_zero", 32'(d2_match), 32'h0);
        sec_zero = 1'b1;
        cyc(1);
        sec_zero = 1'b0;
        check("match_ch1", 32'(d2_match), 32'h2);
        cyc(1);
        check("match_one_cycle", 32'(d2_match), 32'h0);
        isSettingAlarm = 1'b1;
        sec_zero = 1'b1;
        cyc(1);
        sec_zero = 1'b0;
        check("no_match_while_setting", 32'(d2_match), 32'h0);
        isSettingAlarm = 1'b0;
        cmo = 4'd1;
        sec_zero = 1'b1;
        cyc(1);
        sec_zero = 1'b0;
        check("no_match_other_time", 32'(d2_match), 32'h0);
        isSettingAlarm = 1'b1;

        // ---------------- simultaneous keys; out-of-range select ----------------
        do_reset();
        sel2 = 1'b1; sel3 = 2'd3;
        press(1'b1, 1'b1, 1'b1);
        check("simul_ch1_0101", 32'(disp2), 32'h0101);
        check("simul_en_ch1", 32'(d2_en), 32'h2);
        check("sel3_disp_zero", 32'(disp3), 32'h0000);
        check("sel3_en_none", 32'(d3_en), 32'h0);
        for (int c = 0; c < 3; c++) begin
            sel3 = 2'(c);
            cyc(2);
            check($sformatf("sel3_ch%0d_unchanged", c), 32'(disp3), 32'h0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_set_ctrl.md
Name: alarm_set_ctrl

Overview:
- Multi-channel alarm-time setter and comparator for the digital clock.
- Holds NUM_ALARMS BCD alarm times (HH:MM, 24 h) with per-channel enable.
- Lets the user step the selected channel up or down, with hold-to-auto-repeat, and flags a match against the running clock.
- Sits between the key debouncers and the display mux / buzzer driver; successor to the single-channel minute-only setter.

Parameters:
- NUM_ALARMS, 2, number of independent alarm channels (1..8)
- REPEAT_DELAY, 500, clk cycles a key must be held after its first step before auto-repeat starts
- REPEAT_RATE, 100, clk cycles between auto-repeat steps
- CNT_W, 16, width of the hold counter; must hold max(REPEAT_DELAY, REPEAT_RATE)

Ports:
- clk  in  1  system clock; the only clock
- CLR_n  in  1  reset, synchronous, active-high
- isSettingAlarm  in  1  setting mode; keys are ignored when low
- sel_alarm  in  SEL_W=max(1,$clog2(NUM_ALARMS))  channel being set/displayed
- minute_setting  in  1  debounced minute key, level
- hour_setting  in  1  debounced hour key, level
- dir_down  in  1  0 = step up, 1 = step down
- en_toggle  in  1  debounced enable key, level
- cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones  in  4 each  running time, BCD
- sec_zero  in  1  one-cycle pulse when running seconds roll to 00
- alarm_hour_tens, alarm_hour_ones, alarm_minute_tens, alarm_minute_ones  out  4 each  selected channel, BCD, registered
- alarm_en  out  NUM_ALARMS  per-channel enable, registered
- alarm_match  out  NUM_ALARMS  one-cycle match pulse per channel

Behaviour:
- Reset (CLR_n=1 at a clk edge): every channel goes to 00:00. alarm_en=0, alarm_match=0, display outputs 0, key history and hold counters cleared. Reset overrides any in-progress hold or step.
- Key edges:
  - Each key is registered once (key_q). A rise is key & ~key_q.
  - Only rises with isSettingAlarm=1 act.
  - The step lands on the same clk edge that first samples the key high. Display outputs show it 1 cycle later (registered mux).
- Minute field: up wraps 59->00, down wraps 00->59. Ones wrap 9->0 and carry into tens; tens range 0..5. No carry into the hour field.
- Hour field: up wraps 23->00, down wraps 00->23. Ones range 0..9, or 0..3 when tens=2.
- en_toggle rise: alarm_en[sel] inverts. No auto-repeat on this key.
- Auto-repeat, per key (minute, hour):
  - While held, the hold counter counts from the first step.
  - At REPEAT_DELAY cycles: one extra step, counter reloads.
  - Thereafter: one step every REPEAT_RATE cycles.
  - Release, or isSettingAlarm=0, clears the counter immediately.
- Simultaneous minute and hour steps in the same cycle both apply, independently.
- dir_down is sampled each step. Changing it mid-hold changes direction on the next repeat step.
- sel_alarm >= NUM_ALARMS: keys have no effect and display outputs are 0.
- sel_alarm changing mid-hold: later repeat steps go to the new channel; the counter is not reset.
- Match, channel i:
  - alarm_match[i]=1 for exactly one cycle, at the clk edge after sec_zero=1, when alarm_en[i]=1, isSettingAlarm=0, and the running HH:MM equals channel i.
  - No match while setting. Channels are evaluated independently, so several may pulse together.
- Invalid BCD on the cur_* inputs never matches, because stored values are always valid.

Decomposition:
- Package alarm_pkg holds:
  - BCD limits: MIN_TENS_MAX=5, HOUR_TENS_MAX=2, HOUR_ONES_MAX_AT_2=3
  - the SEL_W function
  - typedef bcd_t (4-bit)
  - typedef alarm_time_t (4 x bcd_t)
- One sub-module, key_repeat: edge detect plus hold counter, emits a step pulse. Instantiated twice (minute, hour). Parameters REPEAT_DELAY, REPEAT_RATE, CNT_W.

Test Plan:
- Reset mid-hold, with ch0 at 12:34 and enabled -> next cycle all channels 00:00, alarm_en=0, no further steps until the key is released and pressed again.
- Setting, sel=0, dir up, 61 single minute presses from 00:00 -> ch0 reads 00:01. dir down, one press from 00:00 -> 00:59, hour unchanged.
- sel=1, hour up from 23 -> 00. Hour down from 00 -> 23. Hour up from 19 -> 20, and from 09 -> 10.
- Minute key held for REPEAT_DELAY + 3*REPEAT_RATE cycles from 00:00 -> exactly 5 steps, reading 00:05. Release -> counter 0.
- ch1 set to 07:30, enabled, setting off. Drive 07:30 with a sec_zero pulse -> alarm_match=2'b10 for 1 cycle. Same with isSettingAlarm=1 -> no pulse.
- NUM_ALARMS=2, sel=1, minute and hour pressed in the same cycle from 00:00 -> 01:01. Repeat the same presses from 00:00 at sel=3 (NUM_ALARMS=2 instance, SEL_W=1 cannot encode 3, so use the NUM_ALARMS=3 instance with SEL_W=2) -> no change in any channel, display 00:00.
